// File: rtl/package_settings.sv
// Shared widths and types for the cusp shaping-filter channel.
// Scheduler FSM states and signed filter sample type live here too.
package package_settings;

  localparam int SIZE_ADC_DATA    = 14;
  localparam int SIZE_FILTER_DATA = 23;

  typedef logic [SIZE_ADC_DATA-1:0] adc_t;

  typedef logic signed [SIZE_FILTER_DATA:0] filt_s_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    TRACK,
    REPORT,
    CLEAR
  } sched_state_t;

  localparam filt_s_t FILT_MIN =
    {1'b1, {SIZE_FILTER_DATA{1'b0}}};

  function automatic filt_s_t smax(
    input filt_s_t a,
    input filt_s_t b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cusp_edge_detect.sv
// Leading-edge detector: signed difference of consecutive raw ADC
// samples compared against an unsigned threshold.
module cusp_edge_detect
  import package_settings::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic [SIZE_ADC_DATA-1:0] adc_data,
  input  logic [SIZE_ADC_DATA-1:0] trig_th,
  output logic                     trig
);

  adc_t prev_q;
  adc_t prev_d;

  logic signed [SIZE_ADC_DATA:0] diff;

  always_comb begin
    prev_d = adc_data;
    diff   = $signed({1'b0, adc_data})
           - $signed({1'b0, prev_q});
    trig   = diff > $signed({1'b0, trig_th});
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q <= '0;
    end else begin
      prev_q <= prev_d;
    end
  end

endmodule

// File: rtl/cusp_event_sched.sv
// Event scheduler: trigger, latency wait, peak window, report, filter flush.
// Optional CUSP_PILEUP_FLAG_EN flags triggers seen during WAIT/TRACK.
module cusp_event_sched
  import package_settings::*;
#(
  parameter int TS_W     = 32,
  parameter int WAIT_LEN = 20,
  parameter int WIN_LEN  = 32,
  parameter int CLR_LEN  = 16,
  parameter int CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [SIZE_ADC_DATA-1:0]   adc_data,
  input  logic [SIZE_FILTER_DATA:0]  filt_data,
  input  logic [SIZE_ADC_DATA-1:0]   trig_th,
  output logic                       filt_rst_n,
  output logic                       ev_valid,
  input  logic                       ev_ready,
  output logic [SIZE_FILTER_DATA:0]  ev_amp,
  output logic [TS_W-1:0]            ev_time,
  output logic                       ev_pileup,
  output logic [CNT_W-1:0]           drop_cnt,
  output logic                       busy
);

  localparam int LEN_A   = (WAIT_LEN > WIN_LEN) ? WAIT_LEN : WIN_LEN;
  localparam int LEN_MAX = (LEN_A > CLR_LEN) ? LEN_A : CLR_LEN;
  localparam int CW      = $clog2(LEN_MAX + 1);

  localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_LEN - 1);
  localparam logic [CW-1:0] WIN_LAST  = CW'(WIN_LEN - 1);
  localparam logic [CW-1:0] CLR_LAST  = CW'(CLR_LEN - 1);

  logic trig;
  logic pile_set;

  sched_state_t state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TS_W-1:0] ts_q, ts_d;
  logic [TS_W-1:0] t_lat_q, t_lat_d;
  filt_s_t         peak_q, peak_d;
  logic            pile_q, pile_d;
  logic            filt_rst_n_q, filt_rst_n_d;
  logic            ev_valid_q, ev_valid_d;
  filt_s_t         ev_amp_q, ev_amp_d;
  logic [TS_W-1:0] ev_time_q, ev_time_d;
  logic            ev_pileup_q, ev_pileup_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  cusp_edge_detect u_edge (
    .clk      (clk),
    .reset    (reset),
    .adc_data (adc_data),
    .trig_th  (trig_th),
    .trig     (trig)
  );

`ifdef CUSP_PILEUP_FLAG_EN
  assign pile_set = trig &&
    ((state_q == WAIT) || (state_q == TRACK));
`else
  assign pile_set = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ts_d        = ts_q + TS_W'(1);
    t_lat_d     = t_lat_q;
    peak_d      = peak_q;
    pile_d      = pile_q | pile_set;
    ev_valid_d  = ev_valid_q;
    ev_amp_d    = ev_amp_q;
    ev_time_d   = ev_time_q;
    ev_pileup_d = ev_pileup_q;
    drop_d      = drop_q;

    if (ev_valid_q && ev_ready) begin
      ev_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (trig) begin
          t_lat_d = ts_q;
          cnt_d   = '0;
          pile_d  = 1'b0;
          peak_d  = FILT_MIN;
          state_d = (WAIT_LEN == 0) ? TRACK : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          cnt_d   = '0;
          state_d = TRACK;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      TRACK: begin
        peak_d = smax(peak_q, filt_s_t'(filt_data));
        if (cnt_q == WIN_LAST) begin
          cnt_d   = '0;
          state_d = REPORT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      REPORT: begin
        // a slot freed by this cycle's accept can take the new event
        if (!ev_valid_q || ev_ready) begin
          ev_valid_d  = 1'b1;
          ev_amp_d    = peak_q;
          ev_time_d   = t_lat_q;
          ev_pileup_d = pile_q;
        end else if (drop_q != '1) begin
          drop_d = drop_q + CNT_W'(1);
        end
        cnt_d   = '0;
        state_d = CLEAR;
      end
      CLEAR: begin
        if (cnt_q == CLR_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    filt_rst_n_d = (state_d != CLEAR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ts_q         <= '0;
      t_lat_q      <= '0;
      peak_q       <= FILT_MIN;
      pile_q       <= 1'b0;
      filt_rst_n_q <= 1'b1;
      ev_valid_q   <= 1'b0;
      ev_amp_q     <= '0;
      ev_time_q    <= '0;
      ev_pileup_q  <= 1'b0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ts_q         <= ts_d;
      t_lat_q      <= t_lat_d;
      peak_q       <= peak_d;
      pile_q       <= pile_d;
      filt_rst_n_q <= filt_rst_n_d;
      ev_valid_q   <= ev_valid_d;
      ev_amp_q     <= ev_amp_d;
      ev_time_q    <= ev_time_d;
      ev_pileup_q  <= ev_pileup_d;
      drop_q       <= drop_d;
    end
  end

  assign filt_rst_n = filt_rst_n_q;
  assign ev_valid   = ev_valid_q;
  assign ev_amp     = ev_amp_q;
  assign ev_time    = ev_time_q;
  assign ev_pileup  = ev_pileup_q;
  assign drop_cnt   = drop_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_cusp_event_sched.sv
// Directed table-driven bench for cusp_event_sched.
// Expected pileup depends on CUSP_PILEUP_FLAG_EN.
module tb_cusp_event_sched;
  import package_settings::*;

  localparam int OUT_V   = 20000;
  localparam int TRK0    = 21;
  localparam int LOADV   = 54;
  localparam int CLRLAST = 69;
  localparam int IDLEOFF = 70;
`ifdef CUSP_PILEUP_FLAG_EN
  localparam bit PILE_ON = 1'b1;
`else
  localparam bit PILE_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  adc_t        adc_data;
  adc_t        trig_th;
  filt_s_t     filt_data;
  logic        filt_rst_n;
  logic        ev_valid;
  logic        ev_ready;
  filt_s_t     ev_amp;
  logic [31:0] ev_time;
  logic        ev_pileup;
  logic [15:0] drop_cnt;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int unsigned ts_m;
  int unsigned last_t;

  typedef struct {
    int lo, hi, th;
    int fill, pk, pkpos;
    bit ramp;
    int pile_off, rdy_off;
    bit trig, acc, newev;
    int amp;
    bit pile;
    int drop;
  } vec_t;

  vec_t vt[14];

  cusp_event_sched dut (
    .clk        (clk),
    .reset      (rst_n),
    .adc_data   (adc_data),
    .filt_data  (filt_data),
    .trig_th    (trig_th),
    .filt_rst_n (filt_rst_n),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_amp     (ev_amp),
    .ev_time    (ev_time),
    .ev_pileup  (ev_pileup),
    .drop_cnt   (drop_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_m <= 0;
    else        ts_m <= ts_m + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int fval(input vec_t v, input int off);
    int k;
    k = off - TRK0;
    if (k < 0 || k >= 32) return OUT_V;
    if (k == v.pkpos) return v.pk;
    if (v.ramp) begin
      if (k < v.pkpos) return v.pk * k / v.pkpos;
      return v.pk - 100 * (k - v.pkpos);
    end
    return v.fill;
  endfunction

  task automatic run_vec(input vec_t v, input int id);
    bit quiet;
    string p;
    quiet = 1'b1;
    p = $sformatf("v%0d", id);
    adc_data  = adc_t'(v.lo);
    trig_th   = '1;
    filt_data = filt_s_t'(OUT_V);
    ev_ready  = 1'b0;
    repeat (3) tick();
    trig_th  = adc_t'(v.th);
    adc_data = adc_t'(v.hi);
    if (v.trig && v.newev) last_t = ts_m;
    for (int off = 1; off <= 76; off++) begin
      tick();
      filt_data = filt_s_t'(fval(v, off));
      ev_ready  = (off == v.rdy_off);
      if (off == v.pile_off) adc_data = adc_t'(v.hi + 500);
      if (!v.trig) begin
        if (busy || !filt_rst_n) quiet = 1'b0;
      end else begin
        case (off)
          1: chk({p, " busy_wait"}, longint'(busy), 1);
          LOADV: begin
            chk({p, " rstn_clr"}, longint'(filt_rst_n), 0);
            chk({p, " valid"}, longint'(ev_valid), 1);
            chk({p, " amp"}, longint'(ev_amp), longint'(v.amp));
            chk({p, " time"}, longint'(ev_time), longint'(last_t));
            chk({p, " pileup"}, longint'(ev_pileup),
                longint'(v.pile & PILE_ON));
            chk({p, " drop"}, longint'(drop_cnt), longint'(v.drop));
          end
          CLRLAST: begin
            chk({p, " rstn_last"}, longint'(filt_rst_n), 0);
            chk({p, " busy_clr"}, longint'(busy), 1);
          end
          IDLEOFF: begin
            chk({p, " rstn_idle"}, longint'(filt_rst_n), 1);
            chk({p, " busy_idle"}, longint'(busy), 0);
          end
          default: ;
        endcase
      end
    end
    ev_ready = 1'b0;
    if (!v.trig) begin
      chk({p, " quiet"}, longint'(quiet), 1);
      chk({p, " novalid"}, longint'(ev_valid), 0);
    end
    if (v.acc) begin
      ev_ready = 1'b1;
      tick();
      ev_ready = 1'b0;
      chk({p, " accepted"}, longint'(ev_valid), 0);
    end
  endtask

  initial begin
    // lo hi th | fill pk pkpos ramp | pile rdy | trig acc new | amp pile drop
    vt[0]  = '{100, 400, 200, 0, 5000, 10, 1, -1, -1, 1, 1, 1, 5000, 0, 0};
    vt[1]  = '{100, 250, 200, 0, 0, 0, 0, -1, -1, 0, 0, 0, 0, 0, 0};
    vt[2]  = '{100, 400, 200, -3, -3, 0, 0, -1, -1, 1, 1, 1, -3, 0, 0};
    vt[3]  = '{50, 1000, 200, -100, 1234, 31, 0, -1, -1, 1, 1, 1, 1234, 0, 0};
    vt[4]  = '{200, 500, 100, -50, 777, 0, 0, -1, -1, 1, 1, 1, 777, 0, 0};
    vt[5]  = '{100, 300, 200, 0, 0, 0, 0, -1, -1, 0, 0, 0, 0, 0, 0};
    vt[6]  = '{100, 301, 200, 10, 42, 5, 0, -1, -1, 1, 1, 1, 42, 0, 0};
    vt[7]  = '{100, 400, 200, 0, 111, 3, 0, -1, -1, 1, 0, 1, 111, 0, 0};
    vt[8]  = '{100, 400, 200, 0, 222, 3, 0, -1, -1, 1, 0, 0, 111, 0, 1};
    vt[9]  = '{100, 400, 200, 0, 333, 3, 0, -1, 53, 1, 1, 1, 333, 0, 1};
    vt[10] = '{100, 400, 200, 0, 600, 7, 0, 10, -1, 1, 1, 1, 600, 1, 1};
    vt[11] = '{100, 400, 200, 0, 700, 7, 0, -1, -1, 1, 1, 1, 700, 0, 1};
    vt[12] = '{100, 400, 200, 0, 800, 7, 0, -1, -1, 1, 0, 1, 800, 0, 1};
    vt[13] = '{100, 400, 200, 0, 900, 2, 0, -1, -1, 1, 1, 1, 900, 0, 0};

    adc_data  = '0;
    trig_th   = '1;
    filt_data = '0;
    ev_ready  = 1'b0;
    last_t    = 0;
    #12;
    chk("rst valid", longint'(ev_valid), 0);
    chk("rst rstn", longint'(filt_rst_n), 1);
    chk("rst busy", longint'(busy), 0);
    chk("rst amp", longint'(ev_amp), 0);
    chk("rst time", longint'(ev_time), 0);
    chk("rst drop", longint'(drop_cnt), 0);
    chk("rst pileup", longint'(ev_pileup), 0);
    #1 rst_n = 1'b1;

    for (int i = 0; i <= 12; i++) run_vec(vt[i], i);

    adc_data = 100;
    trig_th  = '1;
    repeat (3) tick();
    trig_th  = 200;
    adc_data = 400;
    repeat (30) tick();
    chk("abort busy_pre", longint'(busy), 1);
    chk("abort valid_pre", longint'(ev_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort valid", longint'(ev_valid), 0);
    chk("abort rstn", longint'(filt_rst_n), 1);
    chk("abort busy", longint'(busy), 0);
    chk("abort drop", longint'(drop_cnt), 0);
    trig_th = '1;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    chk("abort still_idle", longint'(busy), 0);

    run_vec(vt[13], 13);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
